// File: rtl/fetch_stage_pkg.sv
// Shared MIPS32 pipeline definitions: reset/bubble constants, PC step,
// the IF/ID bundle reused by decode, and the next-PC source selector.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [DATA_W-1:0] NOP_WORD   = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080;
    localparam logic [ADDR_W-1:0] PC_STEP    = 32'd4;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc4;
        logic              valid;
    } ifid_t;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_REDIR,
        PC_TRAP
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] pcNew;
    logic [DATA_WIDTH-1:0]    instruct;

    modport master (output pcNew, input instruct);
    modport slave  (input pcNew, output instruct);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load when en, hold otherwise; flush/reset bubble.
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // Reset and flush both insert a bubble; flush outranks a hold.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q.instr <= NOP_WORD;
            q.pc4   <= '0;
            q.valid <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 IF stage: PC register, next-PC mux, IF/ID capture.
// Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects to
// EXC_VECTOR and raises a sticky fetch_exc; otherwise targets are aligned.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [DATA_WIDTH-1:0]    NOP_WORD = mips_pkg::NOP_WORD
`ifdef FETCH_ALIGN_CHECK_EN
    ,parameter logic [ADDRESS_WIDTH-1:0] EXC_VECTOR = mips_pkg::EXC_VECTOR
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_if,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    fetch_stage_if.master            imem,
    output logic [DATA_WIDTH-1:0]    ifid_instr,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc4,
    output logic                     ifid_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,output logic                    fetch_exc
`endif
);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] target_aligned;
    logic                     misaligned;
    pc_sel_e                  pc_sel;
    ifid_t                    ifid_d;
    ifid_t                    ifid_q;

    assign pc_plus4       = pc_q + PC_STEP;
    assign target_aligned = redirect_target & ~ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = redirect_valid && ((redirect_target & ALIGN_MASK) != '0);
`else
    assign misaligned = 1'b0;
`endif

    // Next-PC source: redirect outranks stall; a misaligned redirect traps.
    always_comb begin
        pc_sel = PC_SEQ;
        if (redirect_valid) begin
            pc_sel = misaligned ? PC_TRAP : PC_REDIR;
        end else if (stall_if) begin
            pc_sel = PC_HOLD;
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_next = pc_plus4;
        unique case (pc_sel)
            PC_SEQ:   pc_next = pc_plus4;
            PC_HOLD:  pc_next = pc_q;
            PC_REDIR: pc_next = target_aligned;
`ifdef FETCH_ALIGN_CHECK_EN
            PC_TRAP:  pc_next = EXC_VECTOR;
`else
            PC_TRAP:  pc_next = target_aligned;
`endif
            default:  pc_next = pc_plus4;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_exc <= 1'b0;
        end else if (misaligned) begin
            fetch_exc <= 1'b1;
        end
    end
`endif

    assign imem.pcNew   = pc_q;

    assign ifid_d.instr = imem.instruct;
    assign ifid_d.pc4   = pc_plus4;
    assign ifid_d.valid = 1'b1;

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .en    (!stall_if),
        .flush (redirect_valid),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign ifid_instr = ifid_q.instr;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_valid = ifid_q.valid;

endmodule
